// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, command-word layout, APB address map and requester FSM encoding
package alu_pkg;
    localparam logic [3:0] OP_ADD1 = 4'd1;
    localparam logic [3:0] OP_ADD2 = 4'd2;
    localparam logic [3:0] OP_SUB1 = 4'd3;
    localparam logic [3:0] OP_SUB2 = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_COMP = 4'd9;
    localparam int OPC_LSB   = 28;
    localparam int SHIFT_LSB = 26;
    localparam int CONST_LSB = 22;
    localparam int OP2_LSB   = 14;
    localparam int OP1_LSB   = 6;
    localparam int ADDR_LSB  = 0;
    localparam int ADDR_W    = 6;
    localparam int RES_W     = 9;
    localparam int RESULT_REGS = 16;
    localparam logic [31:0] CMD_READBACK_ADDR = 32'd16;
    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_SETUP, ST_WR_ACCESS, ST_WAIT, ST_RD_SETUP, ST_RD_ACCESS, ST_RESP
    } fsm_t;
endpackage

// File: rtl/alu_apb_requester_if.sv
// alu_apb_requester_if: command, response and APB signals of the ALU requester
interface alu_apb_requester_if;
    import alu_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode;
    logic [1:0]        cmd_shift;
    logic [3:0]        cmd_const;
    logic [7:0]        cmd_op1;
    logic [7:0]        cmd_op2;
    logic [5:0]        cmd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_data;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic              state;
    modport master (
        input  cmd_valid, cmd_opcode, cmd_shift, cmd_const, cmd_op1, cmd_op2, cmd_addr,
        input  rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, state
    );
    modport slave (
        output cmd_valid, cmd_opcode, cmd_shift, cmd_const, cmd_op1, cmd_op2, cmd_addr,
        output rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, state
    );
endinterface

// File: rtl/alu_cmd_pack.sv
// alu_cmd_pack: packs ALU command fields into the 32-bit APB command word
module alu_cmd_pack (
    input  logic [3:0]  opcode,
    input  logic [1:0]  shift,
    input  logic [3:0]  cnst,
    input  logic [7:0]  op1,
    input  logic [7:0]  op2,
    input  logic [5:0]  addr,
    output logic [31:0] word
);
    assign word = {opcode, shift, cnst, op2, op1, addr};
endmodule

// File: rtl/alu_apb_requester.sv
// alu_apb_requester: APB write of an ALU command, compute wait, then APB read of the result
module alu_apb_requester
    import alu_pkg::*;
#(
    parameter int COMPUTE_WAIT    = 4,
    parameter int PREADY_TIMEOUT  = 16,
    parameter int NUM_RESULT_REGS = RESULT_REGS
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_apb_requester_if.master bus
);
    fsm_t             st, nxt;
    logic [31:0]      word, word_in;
    logic [RES_W-1:0] data;
    logic [15:0]      cnt;
    logic             err, tmo, hs, bad, wr, rd, acc, sel, lim, cw_done;
    logic             unused_prdata;

    alu_cmd_pack u_pack (
        .opcode (bus.cmd_opcode),
        .shift  (bus.cmd_shift),
        .cnst   (bus.cmd_const),
        .op1    (bus.cmd_op1),
        .op2    (bus.cmd_op2),
        .addr   (bus.cmd_addr),
        .word   (word_in)
    );

    assign hs      = bus.cmd_valid && st == ST_IDLE;
    assign bad     = int'(bus.cmd_addr) >= NUM_RESULT_REGS;
    assign wr      = st == ST_WR_SETUP || st == ST_WR_ACCESS;
    assign rd      = st == ST_RD_SETUP || st == ST_RD_ACCESS;
    assign acc     = st == ST_WR_ACCESS || st == ST_RD_ACCESS;
    assign sel     = wr || rd;
    assign lim     = cnt == 16'(PREADY_TIMEOUT - 1);
    assign cw_done = cnt == 16'(COMPUTE_WAIT - 1);
    assign unused_prdata = ^bus.prdata[31:RES_W];

    always_comb begin
        nxt = st;
        case (st)
            ST_IDLE:      nxt = hs ? (bad ? ST_RESP : ST_WR_SETUP) : ST_IDLE;
            ST_WR_SETUP:  nxt = ST_WR_ACCESS;
            ST_WR_ACCESS: nxt = bus.pready ? ST_WAIT : (lim ? ST_RESP : ST_WR_ACCESS);
            ST_WAIT:      nxt = cw_done ? ST_RD_SETUP : ST_WAIT;
            ST_RD_SETUP:  nxt = ST_RD_ACCESS;
            ST_RD_ACCESS: nxt = (bus.pready || lim) ? ST_RESP : ST_RD_ACCESS;
            ST_RESP:      nxt = bus.rsp_ready ? ST_IDLE : ST_RESP;
            default:      nxt = ST_IDLE;
        endcase
    end

    // cnt restarts on every state change, so it times both WAIT and each ACCESS phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st   <= ST_IDLE;
            word <= '0;
            data <= '0;
            cnt  <= '0;
            err  <= 1'b0;
            tmo  <= 1'b0;
        end else begin
            st  <= nxt;
            cnt <= (nxt != st) ? '0 : cnt + 16'd1;
            if (hs) begin
                word <= word_in;
                data <= '0;
                err  <= bad;
                tmo  <= 1'b0;
            end
            if (acc && bus.pready)
                err <= err | bus.pslverr;
            if (st == ST_RD_ACCESS && bus.pready)
                data <= bus.prdata[RES_W-1:0];
            if (acc && !bus.pready && lim)
                tmo <= 1'b1;
        end
    end

    assign bus.cmd_ready   = st == ST_IDLE;
    assign bus.rsp_valid   = st == ST_RESP;
    assign bus.rsp_data    = data;
    assign bus.rsp_err     = err;
    assign bus.rsp_timeout = tmo;
    assign bus.psel        = sel;
    assign bus.state       = sel;
    assign bus.penable     = acc;
    assign bus.pwrite      = wr;
    assign bus.paddr       = rd ? 32'(word[ADDR_LSB +: ADDR_W]) : '0;
    assign bus.pwdata      = wr ? word : '0;
endmodule
